// File: rtl/des_pkg.sv
// Shared types and constants for the DE2 panel controller and its debouncers.
// Chunk helper writes one 16-bit slice of a 64-bit block register.
package des_pkg;

    localparam int unsigned DES_BLOCK_W = 64;
    localparam int unsigned DES_CHUNK_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } des_state_e;

    typedef enum logic [1:0] {
        CHUNK_15_0  = 2'd0,
        CHUNK_31_16 = 2'd1,
        CHUNK_47_32 = 2'd2,
        CHUNK_63_48 = 2'd3
    } des_chunk_e;

    function automatic logic [DES_BLOCK_W-1:0] put_chunk(
        input logic [DES_BLOCK_W-1:0] blk,
        input logic [1:0]             sel,
        input logic [DES_CHUNK_W-1:0] word
    );
        logic [DES_BLOCK_W-1:0] r;
        r = blk;
        case (des_chunk_e'(sel))
            CHUNK_15_0:  r[15:0]  = word;
            CHUNK_31_16: r[31:16] = word;
            CHUNK_47_32: r[47:32] = word;
            CHUNK_63_48: r[63:48] = word;
            default:     r = blk;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/des_btn_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchroniser, stability counter,
// and a single-cycle pulse on the accepted press (1->0) transition.
module des_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          flip;

    // flip marks the DEBOUNCE_CYCLES-th consecutive sample that disagrees with level
    assign flip = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn_n};
            press <= flip && level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/des_panel_ctrl.sv
// Panel sequencer: debounced KEY buttons load data/key chunks from SW and
// issue encrypt/decrypt commands to the DES core, latching its result.
module des_panel_ctrl
    import des_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned TIMEOUT_CYCLES  = 64,
    parameter logic [63:0] DEFAULT_DATA    = 64'h0123456789ABCDEF,
    parameter logic [63:0] DEFAULT_KEY     = 64'h133457799BBCDFF1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_enc_n,
    input  logic                   btn_dec_n,
    input  logic                   btn_load_n,
    input  logic [1:0]             sw_sel,
    input  logic                   sw_tgt,
    input  logic [DES_CHUNK_W-1:0] sw_word,
    output logic                   des_start,
    output logic                   des_decrypt,
    output logic [DES_BLOCK_W-1:0] des_data,
    output logic [DES_BLOCK_W-1:0] des_key,
    input  logic                   des_done,
    input  logic [DES_BLOCK_W-1:0] des_result,
    output logic [DES_BLOCK_W-1:0] result_q,
    output logic                   ready,
    output logic                   enc_active,
    output logic                   dec_active,
    output logic                   err_timeout
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    des_state_e    state, state_d;
    logic [TW-1:0] timer;
    logic          enc_ev, dec_ev, load_ev;
    logic          acc_enc, acc_dec, acc_load, complete, timed_out;

    des_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enc (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_enc_n), .press(enc_ev)
    );
    des_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_dec_n), .press(dec_ev)
    );
    des_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_load_n), .press(load_ev)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        des_start = 1'b0;
        ready     = 1'b0;
        acc_enc   = 1'b0;
        acc_dec   = 1'b0;
        acc_load  = 1'b0;
        complete  = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                // enc > dec > load; losers in the same cycle are dropped
                if (enc_ev) begin
                    acc_enc = 1'b1;
                    state_d = ISSUE;
                end else if (dec_ev) begin
                    acc_dec = 1'b1;
                    state_d = ISSUE;
                end else if (load_ev) begin
                    acc_load = 1'b1;
                end
            end
            ISSUE: begin
                des_start = 1'b1;
                if (des_done) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (des_done) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    timed_out = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= '0;
            des_decrypt <= 1'b0;
            enc_active  <= 1'b0;
            dec_active  <= 1'b0;
            err_timeout <= 1'b0;
            result_q    <= '0;
            des_data    <= DEFAULT_DATA;
            des_key     <= DEFAULT_KEY;
        end else begin
            timer <= (state == WAIT) ? timer + 1'b1 : '0;
            if (acc_enc || acc_dec) begin
                des_decrypt <= acc_dec;
                enc_active  <= acc_enc;
                dec_active  <= acc_dec;
                err_timeout <= 1'b0;
            end
            if (complete) begin
                result_q   <= des_result;
                enc_active <= 1'b0;
                dec_active <= 1'b0;
            end
            if (timed_out) begin
                err_timeout <= 1'b1;
                enc_active  <= 1'b0;
                dec_active  <= 1'b0;
            end
            if (acc_load) begin
                if (sw_tgt) begin
                    des_key <= put_chunk(des_key, sw_sel, sw_word);
                end else begin
                    des_data <= put_chunk(des_data, sw_sel, sw_word);
                end
            end
        end
    end

endmodule

// File: tb/tb_des_panel_ctrl.sv
// Scoreboard bench for des_panel_ctrl with a lookup-based DES core stand-in.
module tb_des_panel_ctrl;

    localparam logic [63:0] DEF_DATA = 64'h0123456789ABCDEF;
    localparam logic [63:0] DEF_KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] CIPHER   = 64'h85E813540F0AB405;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_enc_n = 1'b1, btn_dec_n = 1'b1, btn_load_n = 1'b1;
    logic [1:0]  sw_sel = 2'd0;
    logic        sw_tgt = 1'b0;
    logic [15:0] sw_word = 16'h0;
    logic        des_start, des_decrypt, des_done;
    logic [63:0] des_data, des_key, des_result, result_q;
    logic        ready, enc_active, dec_active, err_timeout;

    logic        core_done = 1'b0, stray_done = 1'b0;
    logic [63:0] core_res = '0, stray_res = '0;
    assign des_done   = core_done | stray_done;
    assign des_result = stray_done ? stray_res : core_res;

    always #5 clk = ~clk;

    des_panel_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_enc_n(btn_enc_n), .btn_dec_n(btn_dec_n), .btn_load_n(btn_load_n),
        .sw_sel(sw_sel), .sw_tgt(sw_tgt), .sw_word(sw_word),
        .des_start(des_start), .des_decrypt(des_decrypt),
        .des_data(des_data), .des_key(des_key),
        .des_done(des_done), .des_result(des_result),
        .result_q(result_q), .ready(ready),
        .enc_active(enc_active), .dec_active(dec_active), .err_timeout(err_timeout)
    );

    function automatic logic [63:0] des_ref(input logic [63:0] d, input logic [63:0] k, input logic dec);
        if (d == DEF_DATA && k == DEF_KEY && !dec) return CIPHER;
        if (d == CIPHER && k == DEF_KEY && dec) return DEF_DATA;
        return {d[31:0], d[63:32]} ^ k ^ {64{dec}};
    endfunction

    // core stand-in: answers core_lat cycles after des_start (0 = same cycle)
    int   core_lat = 2;
    bit   core_respond = 1'b1;
    bit   core_busy = 1'b0;
    int   core_cnt = 0;
    logic [63:0] core_pend = '0;
    always @(negedge clk) begin
        core_done = 1'b0;
        if (!rst_n) core_busy = 1'b0;
        if (core_busy) begin
            if (core_cnt == 0) begin
                core_done = 1'b1;
                core_res  = core_pend;
                core_busy = 1'b0;
            end else begin
                core_cnt--;
            end
        end
        if (des_start && core_respond) begin
            core_pend = des_ref(des_data, des_key, des_decrypt);
            if (core_lat == 0) begin
                core_done = 1'b1;
                core_res  = core_pend;
            end else begin
                core_busy = 1'b1;
                core_cnt  = core_lat - 1;
            end
        end
    end

    int   cyc = 0, start_cnt = 0, start_cyc = 0, rise_cyc = 0;
    logic mon_mode = 1'b0, mon_ready = 1'b0, mon_enc_act = 1'b0, mon_dec_act = 1'b0, mon_err = 1'b0;
    logic ready_prev = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (des_start) begin
            start_cnt++;
            start_cyc   = cyc;
            mon_mode    = des_decrypt;
            mon_ready   = ready;
            mon_enc_act = enc_active;
            mon_dec_act = dec_active;
            mon_err     = err_timeout;
        end
        if (ready && !ready_prev) rise_cyc = cyc;
        ready_prev = ready;
    end

    typedef struct {
        logic        mode;
        logic [63:0] res;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0, n_bad = 0;
    logic [63:0] m_data = DEF_DATA, m_key = DEF_KEY, m_result = '0;

    task automatic press(input int which, input int hold);
        @(negedge clk);
        if (which & 1) btn_enc_n = 1'b0;
        if (which & 2) btn_dec_n = 1'b0;
        if (which & 4) btn_load_n = 1'b0;
        repeat (hold) @(negedge clk);
        btn_enc_n = 1'b1; btn_dec_n = 1'b1; btn_load_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (!ready) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: ready still %b after %0d cycles, want 1", name, ready, n);
        end
    endtask

    task automatic load_chunk(input logic tgt, input int sel, input logic [15:0] word);
        sw_tgt = tgt; sw_sel = 2'(sel); sw_word = word;
        press(4, 8);
        if (tgt) m_key[sel*16 +: 16] = word;
        else     m_data[sel*16 +: 16] = word;
    endtask

    task automatic check_result(input string name);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, result_q=%h", name, result_q);
            return;
        end
        e = exp_q.pop_front();
        m_result = e.res;
        if (result_q !== e.res) begin
            n_bad++;
            $display("FAIL %s result_q: got %h want %h", name, result_q, e.res);
        end
        n_cmp++;
        if (mon_mode !== e.mode) begin
            n_bad++;
            $display("FAIL %s des_decrypt at start: got %b want %b", name, mon_mode, e.mode);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ready, des_start, des_decrypt, enc_active, dec_active, err_timeout} !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset flags: got %b want 100000",
                     {ready, des_start, des_decrypt, enc_active, dec_active, err_timeout});
        end
        n_cmp++;
        if (des_data !== DEF_DATA) begin n_bad++; $display("FAIL reset des_data: got %h want %h", des_data, DEF_DATA); end
        n_cmp++;
        if (des_key !== DEF_KEY) begin n_bad++; $display("FAIL reset des_key: got %h want %h", des_key, DEF_KEY); end
        n_cmp++;
        if (result_q !== 64'h0) begin n_bad++; $display("FAIL reset result_q: got %h want 0", result_q); end
    endtask

    task automatic test_encrypt_default();
        int s0 = start_cnt;
        core_lat = 3;
        exp_q.push_back('{mode: 1'b0, res: CIPHER});
        press(1, 8);
        wait_idle("enc_default");
        check_result("enc_default");
        n_cmp++;
        if (start_cnt - s0 != 1) begin n_bad++; $display("FAIL enc_default start pulses: got %0d want 1", start_cnt - s0); end
        n_cmp++;
        if ({mon_ready, mon_enc_act, mon_dec_act} !== 3'b010) begin
            n_bad++;
            $display("FAIL enc_default ready/enc/dec at start: got %b want 010", {mon_ready, mon_enc_act, mon_dec_act});
        end
        n_cmp++;
        if ({enc_active, dec_active} !== 2'b00) begin n_bad++; $display("FAIL enc_default active after: got %b want 00", {enc_active, dec_active}); end
    endtask

    task automatic test_load_decrypt();
        int s0;
        load_chunk(1'b0, 3, 16'h85E8);
        load_chunk(1'b0, 2, 16'h1354);
        load_chunk(1'b0, 1, 16'h0F0A);
        load_chunk(1'b0, 0, 16'hB405);
        n_cmp++;
        if (des_data !== CIPHER) begin n_bad++; $display("FAIL load des_data: got %h want %h", des_data, CIPHER); end
        load_chunk(1'b1, 1, 16'hBEEF);
        n_cmp++;
        if (des_key !== m_key) begin n_bad++; $display("FAIL load des_key slice: got %h want %h", des_key, m_key); end
        load_chunk(1'b1, 1, 16'h9BBC);
        n_cmp++;
        if (des_key !== DEF_KEY) begin n_bad++; $display("FAIL restore des_key: got %h want %h", des_key, DEF_KEY); end
        s0 = start_cnt;
        core_lat = 2;
        exp_q.push_back('{mode: 1'b1, res: DEF_DATA});
        press(2, 8);
        wait_idle("dec");
        check_result("dec");
        n_cmp++;
        if ({start_cnt - s0, mon_dec_act} !== {32'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL dec start count/dec_active: got %0d/%b want 1/1", start_cnt - s0, mon_dec_act);
        end
    endtask

    task automatic test_glitch_and_simultaneous();
        int s0 = start_cnt;
        press(1, 2);
        press(1, 3);
        n_cmp++;
        if (start_cnt != s0) begin n_bad++; $display("FAIL glitch start pulses: got %0d want 0", start_cnt - s0); end
        exp_q.push_back('{mode: 1'b0, res: des_ref(m_data, m_key, 1'b0)});
        press(1, 4);
        wait_idle("threshold_press");
        check_result("threshold_press");
        s0 = start_cnt;
        exp_q.push_back('{mode: 1'b0, res: des_ref(m_data, m_key, 1'b0)});
        press(3, 8);
        wait_idle("simultaneous");
        check_result("simultaneous");
        n_cmp++;
        if (start_cnt - s0 != 1) begin n_bad++; $display("FAIL simultaneous start pulses: got %0d want 1", start_cnt - s0); end
    endtask

    task automatic test_busy_drop();
        int s0 = start_cnt;
        core_lat = 60;
        exp_q.push_back('{mode: 1'b0, res: des_ref(m_data, m_key, 1'b0)});
        press(1, 8);
        n_cmp++;
        if ({ready, enc_active} !== 2'b01) begin n_bad++; $display("FAIL busy ready/enc_active: got %b want 01", {ready, enc_active}); end
        sw_tgt = 1'b0; sw_sel = 2'd0; sw_word = 16'h1234;
        press(2, 8);
        press(4, 8);
        wait_idle("busy_drop");
        check_result("busy_drop");
        n_cmp++;
        if (des_data !== m_data) begin n_bad++; $display("FAIL busy des_data: got %h want %h", des_data, m_data); end
        n_cmp++;
        if (start_cnt - s0 != 1) begin n_bad++; $display("FAIL busy start pulses: got %0d want 1", start_cnt - s0); end
    endtask

    task automatic test_timeout();
        core_respond = 1'b0;
        press(1, 8);
        wait_idle("timeout");
        n_cmp++;
        if ({err_timeout, ready, enc_active} !== 3'b110) begin
            n_bad++;
            $display("FAIL timeout err/ready/enc: got %b want 110", {err_timeout, ready, enc_active});
        end
        n_cmp++;
        if (result_q !== m_result) begin n_bad++; $display("FAIL timeout result_q: got %h want %h", result_q, m_result); end
        n_cmp++;
        if (rise_cyc - start_cyc != 65) begin n_bad++; $display("FAIL timeout latency: got %0d want 65", rise_cyc - start_cyc); end
        core_respond = 1'b1;
        core_lat = 0;
        exp_q.push_back('{mode: 1'b0, res: des_ref(m_data, m_key, 1'b0)});
        press(1, 8);
        wait_idle("done_in_issue");
        check_result("done_in_issue");
        n_cmp++;
        if ({mon_err, err_timeout} !== 2'b00) begin n_bad++; $display("FAIL err clear at start/after: got %b want 00", {mon_err, err_timeout}); end
    endtask

    task automatic test_reset_mid_op();
        int s0 = start_cnt;
        int n = 0;
        core_lat = 40;
        @(negedge clk);
        btn_enc_n = 1'b0;
        while (start_cnt == s0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        btn_enc_n = 1'b1;
        n_cmp++;
        if (start_cnt == s0) begin n_bad++; $display("FAIL midreset: no des_start within %0d cycles", n); end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ready, des_start, des_decrypt, enc_active, dec_active, err_timeout} !== 6'b100000) begin
            n_bad++;
            $display("FAIL midreset flags: got %b want 100000",
                     {ready, des_start, des_decrypt, enc_active, dec_active, err_timeout});
        end
        n_cmp++;
        if ({des_data, result_q} !== {DEF_DATA, 64'h0}) begin
            n_bad++;
            $display("FAIL midreset data/result: got %h/%h want %h/0", des_data, result_q, DEF_DATA);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_data = DEF_DATA; m_key = DEF_KEY; m_result = '0;
        s0 = start_cnt;
        repeat (2) @(negedge clk);
        stray_res  = 64'hDEAD_BEEF_CAFE_F00D;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (result_q !== 64'h0) begin n_bad++; $display("FAIL stray done result_q: got %h want 0", result_q); end
        n_cmp++;
        if ({ready, start_cnt - s0} !== {1'b1, 32'd0}) begin
            n_bad++;
            $display("FAIL stray done ready/starts: got %b/%0d want 1/0", ready, start_cnt - s0);
        end
    endtask

    initial begin
        test_reset();
        test_encrypt_default();
        test_load_decrypt();
        test_glitch_and_simultaneous();
        test_busy_drop();
        test_timeout();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/des_panel_ctrl.md
Name: des_panel_ctrl

Overview:
Sequencing controller between the DE2 board inputs (KEY pushbuttons, SW switches) and the DES core. It debounces the buttons and loads the 64-bit data and key registers in 16-bit chunks. It also issues encrypt/decrypt commands to the core, waits for completion, and latches the result. The board top instantiates it between raw I/O and the DES core; its status outputs drive the LEDG/HEX logic.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable samples before a button level is accepted (5 ms at 50 MHz; benches use 4).
TIMEOUT_CYCLES, 64, maximum wait for des_done before abort.
DEFAULT_DATA, 64'h0123456789ABCDEF, data register reset value.
DEFAULT_KEY, 64'h133457799BBCDFF1, key register reset value.

Ports:
clk  in  1  system clock (50 MHz).
rst_n  in  1  asynchronous active-low reset.
btn_enc_n  in  1  raw encrypt button (KEY[1]), active low.
btn_dec_n  in  1  raw decrypt button (KEY[2]), active low.
btn_load_n  in  1  raw chunk-load button (KEY[3]), active low.
sw_sel  in  2  chunk select: 0=[15:0], 1=[31:16], 2=[47:32], 3=[63:48].
sw_tgt  in  1  load target: 0=data register, 1=key register.
sw_word  in  16  chunk value.
des_start  out  1  one-cycle command pulse to the core.
des_decrypt  out  1  mode, valid while des_start=1 and held through the operation.
des_data  out  64  data register.
des_key  out  64  key register.
des_done  in  1  core completion pulse.
des_result  in  64  core output, valid with des_done.
result_q  out  64  last completed result.
ready  out  1  1 in IDLE.
enc_active  out  1  encrypt operation in flight.
dec_active  out  1  decrypt operation in flight.
err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; des_data=DEFAULT_DATA; des_key=DEFAULT_KEY; result_q=0; des_start=0; des_decrypt=0; ready=1; enc_active=dec_active=0; err_timeout=0; debouncers treat all buttons as released.
- Reset asserted mid-operation: immediate return to the reset state. A late des_done after reset is ignored.
- Debounce, per button:
  - 2-flop synchroniser, then a counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive samples differing from the current level. Any mismatch-free sample resets the count.
  - A press event is a single-cycle pulse on the debounced 1->0 transition. Release generates nothing.
  - A glitch shorter than DEBOUNCE_CYCLES produces no event.
- Load event, accepted in IDLE only:
  - The 16-bit slice sw_sel of the register chosen by sw_tgt is written with sw_word on the event cycle.
  - Other slices are unchanged. Load events outside IDLE are dropped.
- FSM:
  - IDLE: an enc or dec event moves to ISSUE.
  - ISSUE: one cycle; des_start=1.
  - WAIT: on des_done, go to IDLE.
  - Timeout: in WAIT, after TIMEOUT_CYCLES, go to IDLE.
- Command accept, in IDLE:
  - Priority on simultaneous events: enc > dec > load. Lower-priority events in the same cycle are dropped.
  - On accept: des_decrypt is set (0 for enc, 1 for dec); enc_active or dec_active is set; err_timeout is cleared; ready=0.
- Latency:
  - Event in cycle N gives des_start=1 in cycle N+1 only.
  - ready is low from N+1 until des_done is sampled.
- Completion: des_done sampled in WAIT (cycle M). In M+1:
  - result_q=des_result, stored unswapped;
  - ready=1;
  - active flags cleared.
- des_done in the same cycle as des_start (ISSUE) is honoured identically.
- des_done outside ISSUE/WAIT is ignored.
- Timeout: a counter starts at 0 on entry to WAIT. When it reaches TIMEOUT_CYCLES-1 without des_done:
  - err_timeout=1, sticky;
  - FSM goes to IDLE;
  - result_q is unchanged.
- Events while busy are dropped, not queued.
- des_data and des_key are stable from ISSUE through completion.

Decomposition:
- Shared package des_pkg: FSM state enum (IDLE, ISSUE, WAIT), chunk-select constants, DES_BLOCK_W=64, DES_CHUNK_W=16.
- One sub-module, des_btn_debounce (parameter DEBOUNCE_CYCLES): synchroniser, counter, press pulse. Instantiated three times.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4 and a behavioural DES core model.
1. Reset, then an encrypt press with defaults -> single des_start pulse with des_decrypt=0; result_q=85E813540F0AB405; ready returns to 1.
2. Load 85E8/1354/0F0A/B405 into data chunks 3..0, then a decrypt press -> des_data=85E813540F0AB405, des_decrypt=1, result_q=0123456789ABCDEF.
3. 2-cycle low glitch on btn_enc_n -> no des_start. Simultaneous enc+dec press -> exactly one start with des_decrypt=0.
4. Encrypt, then dec and load presses during WAIT -> both dropped; des_data unchanged; exactly one des_start total.
5. Core stub never asserts done -> err_timeout=1 after 64 cycles in WAIT; ready=1; result_q unchanged. The next encrypt clears err_timeout.
6. rst_n pulsed low during WAIT -> outputs at reset values within the same cycle; a subsequent stray des_done leaves result_q=0.
